// File: rtl/text_line_buffer_if.sv
// Byte-stream handshake between a character source and the text line buffer.
interface text_line_buffer_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/text_line_buffer.sv
// One editable line of ASCII text with a blinking cursor, read out combinationally
// as a glyph-ROM address for the pixel currently being drawn.
module text_line_buffer #(
  parameter int unsigned NUM_COLS     = 17,
  parameter int unsigned X_START      = 0,
  parameter int unsigned Y_START      = 192,
  parameter int unsigned CHAR_W       = 16,
  parameter int unsigned CHAR_H       = 16,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [9:0]                        x,
  input  logic [9:0]                        y,
  text_line_buffer_if.slave                 wr,
  output logic [6:0]                        char_addr,
  output logic [$clog2(NUM_COLS+1)-1:0]     cursor_col,
  output logic                              overflow
);

  localparam int unsigned CW  = $clog2(NUM_COLS + 1);
  localparam int unsigned FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned ShW = $clog2(CHAR_W);
  localparam logic [CW-1:0] LastCol   = CW'(NUM_COLS - 1);
  localparam logic [CW-1:0] FullCol   = CW'(NUM_COLS);
  localparam logic [FW-1:0] LastFrame = FW'(BLINK_FRAMES - 1);
  localparam int unsigned WinW = NUM_COLS * CHAR_W;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] clr_idx_q, clr_idx_d;
  logic [CW-1:0] cursor_q, cursor_d;
  logic          overflow_q, overflow_d;
  logic          blink_q, blink_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          origin_q;

  logic [6:0]    mem_q [NUM_COLS];
  logic          mem_we;
  logic [CW-1:0] mem_waddr;
  logic [6:0]    mem_wdata;

  logic          wr_ready;
  logic          at_origin;
  logic          tick;

  // Control FSM: clear sweep, then byte interpretation on each transfer
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    cursor_d   = cursor_q;
    overflow_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = 7'h20;
    wr_ready   = 1'b0;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        if (clr_idx_q == LastCol) begin
          clr_idx_d = '0;
          state_d   = StIdle;
        end else begin
          clr_idx_d = clr_idx_q + CW'(1);
        end
      end
      StIdle: begin
        wr_ready = 1'b1;
        if (wr.wr_valid) begin
          if (wr.wr_data >= 8'h20 && wr.wr_data <= 8'h7E) begin
            if (cursor_q < FullCol) begin
              mem_we    = 1'b1;
              mem_waddr = cursor_q;
              mem_wdata = wr.wr_data[6:0];
              cursor_d  = cursor_q + CW'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end else begin
            case (wr.wr_data)
              8'h08: begin
                if (cursor_q != '0) begin
                  cursor_d  = cursor_q - CW'(1);
                  mem_we    = 1'b1;
                  mem_waddr = cursor_q - CW'(1);
                end
              end
              8'h0D: cursor_d = '0;
              8'h0C: begin
                cursor_d  = '0;
                clr_idx_d = '0;
                state_d   = StClear;
              end
              default: ;  // control bytes we do not interpret are swallowed
            endcase
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Frame tick on the rising edge of the (0,0) pixel; blink phase flips every BLINK_FRAMES ticks
  always_comb begin
    at_origin = (x == 10'd0) && (y == 10'd0);
    tick      = at_origin & ~origin_q;
    frame_d   = frame_q;
    blink_d   = blink_q;
    if (tick) begin
      if (frame_q == LastFrame) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  // Control and blink state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StClear;
      clr_idx_q  <= '0;
      cursor_q   <= '0;
      overflow_q <= 1'b0;
      blink_q    <= 1'b0;
      frame_q    <= '0;
      origin_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      cursor_q   <= cursor_d;
      overflow_q <= overflow_d;
      blink_q    <= blink_d;
      frame_q    <= frame_d;
      origin_q   <= at_origin;
    end
  end

  // Character storage; contents are defined only by the clear sweep
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Zero-latency read path; offsets wrap huge when left/above the window
  logic [31:0]   x_off, y_off;
  logic [CW-1:0] col_idx;
  logic          in_win;
  always_comb begin
    x_off   = {22'd0, x} - X_START;
    y_off   = {22'd0, y} - Y_START;
    in_win  = (x_off < WinW) && (y_off < CHAR_H);
    col_idx = CW'(x_off >> ShW);
    if (!in_win) begin
      char_addr = 7'h20;
    end else if (col_idx == cursor_q && cursor_q < FullCol && blink_q) begin
      char_addr = 7'h5F;
    end else begin
      char_addr = mem_q[col_idx];
    end
  end

  assign wr.wr_ready = wr_ready;
  assign cursor_col  = cursor_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_text_line_buffer.sv
// Scoreboard bench for text_line_buffer: stimulus queues expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_text_line_buffer;

  localparam int IdleX = 600;
  localparam int IdleY = 400;

  logic       clk;
  logic       reset;
  logic [9:0] x, y;
  logic [6:0] char_addr;
  logic [4:0] cursor_col;
  logic       overflow;

  text_line_buffer_if wr_if ();

  text_line_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .wr         (wr_if),
    .char_addr  (char_addr),
    .cursor_col (cursor_col),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         kind;  // 0 char_addr, 1 cursor_col, 2 wr_ready, 3 overflow
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Monitor: compare every queued expectation against the outputs at this negedge
  always @(negedge clk) begin
    exp_t       it;
    logic [7:0] act;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.kind)
        0:       act = {1'b0, char_addr};
        1:       act = {3'b000, cursor_col};
        2:       act = {7'd0, wr_if.wr_ready};
        default: act = {7'd0, overflow};
      endcase
      n_checks++;
      if (act !== it.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  // Queue one expectation; returns at the following negedge + 1 (never crosses a posedge)
  task automatic chk(input int kind, input logic [7:0] exp, input string name);
    exp_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb_q.push_back(it);
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input int xx, input int yy, input logic [7:0] exp, input string name);
    x = 10'(xx);
    y = 10'(yy);
    chk(0, exp, name);
    x = 10'(IdleX);
    y = 10'(IdleY);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (wr_if.wr_ready !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (wr_if.wr_ready !== 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL send_wait: got wr_ready=%b expected 1 within 40 cycles", wr_if.wr_ready);
    end
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = b;
    @(posedge clk);
    #1;
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      x = 10'd0;
      y = 10'd0;
      @(posedge clk);
      #1;
      x = 10'(IdleX);
      y = 10'(IdleY);
      @(posedge clk);
      #1;
    end
  endtask

  // Caller must be at posedge + 1 right after clear started
  task automatic clear_window(input string tag);
    for (int i = 0; i < 17; i++) chk(2, 8'h00, $sformatf("%s_busy%0d", tag, i));
    chk(2, 8'h01, {tag, "_ready"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b0;
    x              = 10'(IdleX);
    y              = 10'(IdleY);
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk(2, 8'h00, "rst_ready");
    chk(3, 8'h00, "rst_overflow");
    chk(1, 8'h00, "rst_cursor");

    // 1: reset release, clear sweep, blank line
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_window("init");
    for (int c = 0; c < 17; c++) rd(c * 16 + 7, 195, 8'h20, $sformatf("init_col%0d", c));
    chk(1, 8'h00, "init_cursor");

    // 2: "HI" and cursor blink
    send(8'h48);
    chk(3, 8'h00, "hi_no_overflow");
    send(8'h49);
    rd(0, 192, 8'h48, "hi_col0");
    rd(16, 192, 8'h49, "hi_col1");
    chk(1, 8'd2, "hi_cursor");
    rd(32, 192, 8'h20, "hi_cursor_blink0");
    ticks(30);
    rd(32, 192, 8'h5F, "hi_cursor_blink1");
    rd(0, 192, 8'h48, "hi_col0_blink1");

    // 3: 18 'A' back to back, last one overflows
    send(8'h0D);
    for (int i = 0; i < 18; i++) begin
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 8'h41;
      @(posedge clk);
      #1;
      chk(3, (i == 17) ? 8'h01 : 8'h00, $sformatf("fill_ovf%0d", i));
    end
    wr_if.wr_valid = 1'b0;
    chk(3, 8'h00, "fill_ovf_pulse_end");
    chk(1, 8'd17, "fill_cursor");
    rd(264, 192, 8'h41, "fill_col16");
    rd(271, 192, 8'h41, "fill_x271");
    rd(272, 192, 8'h20, "fill_x272");
    rd(0, 207, 8'h41, "fill_y207");
    rd(0, 208, 8'h20, "fill_y208");
    rd(0, 191, 8'h20, "fill_y191");

    // 4: backspace, including one at column 0
    ticks(30);  // blink back to 0
    send(8'h0D);
    send(8'h41);
    send(8'h42);
    send(8'h08);
    chk(1, 8'd1, "bs_cursor1");
    send(8'h08);
    send(8'h08);
    chk(1, 8'd0, "bs_cursor0");
    rd(0, 192, 8'h20, "bs_col0");
    rd(16, 192, 8'h20, "bs_col1");
    rd(32, 192, 8'h41, "bs_col2");

    // 5: CR overwrite, ignored bytes, form feed, reset during clear
    send(8'h58);
    send(8'h59);
    send(8'h5A);
    send(8'h0D);
    send(8'h51);
    send(8'h0A);
    send(8'h7F);
    send(8'h80);
    rd(0, 192, 8'h51, "cr_col0");
    rd(16, 192, 8'h59, "cr_col1");
    rd(32, 192, 8'h5A, "cr_col2");
    rd(48, 192, 8'h41, "cr_col3");
    chk(1, 8'd1, "cr_cursor");
    send(8'h0C);
    clear_window("ff");
    for (int c = 0; c < 17; c++) rd(c * 16, 192, 8'h20, $sformatf("ff_col%0d", c));
    chk(1, 8'd0, "ff_cursor");
    send(8'h4D);
    send(8'h4E);
    send(8'h0C);
    for (int i = 0; i < 3; i++) chk(2, 8'h00, $sformatf("midclr_busy%0d", i));
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_window("reclr");
    rd(0, 192, 8'h20, "reclr_col0");
    rd(16, 192, 8'h20, "reclr_col1");
    chk(1, 8'd0, "reclr_cursor");

    // 6: blink toggles exactly at 30 and 60 ticks; window edges stay blank
    ticks(29);
    rd(0, 192, 8'h20, "blink_t29");
    ticks(1);
    rd(0, 192, 8'h5F, "blink_t30");
    rd(0, 208, 8'h20, "blink_y208");
    rd(272, 192, 8'h20, "blink_x272");
    ticks(29);
    rd(0, 192, 8'h5F, "blink_t59");
    ticks(1);
    rd(0, 192, 8'h20, "blink_t60");

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
